// File: rtl/cache_set_ctrl.sv
// ============================================================================
// cache_set_ctrl
//   Initiator-side controller for one 4-way cache set array. Accepts CPU
//   load/store requests and steps them through tag compare, optional dirty
//   write-back + evict, line fetch + fill and a re-compare, then signals
//   completion to the CPU. Backing memory is reached over a req/ack handshake.
//
//   Optional build macro: CACHE_CTRL_STATS_EN adds saturating hit/miss
//   counters (stat_hits, stat_misses). Undefined by default.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   cpu_req/we/addr   CPU request (sampled only when idle)
//   cpu_ready/hit     one-cycle completion pulse, first-compare hit flag
//   set_index/tag     latched index/tag presented to the set array
//   set_en*           set strobes: enable, check, alloc, evict, change
//   set_hit/dirty/valid/victim_tag  status from the selected set
//   mem_req/we/addr   line-aligned memory request, held until mem_ack
//   mem_ack           memory completion
//   stat_hits/misses  (CACHE_CTRL_STATS_EN only) saturating counters
// ============================================================================
module cache_set_ctrl #(
    parameter int TAG_W    = 19,
    parameter int INDEX_W  = 9,
    parameter int OFFSET_W = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cpu_req,
    input  logic                                cpu_we,
    input  logic [TAG_W+INDEX_W+OFFSET_W-1:0]   cpu_addr,
    output logic                                cpu_ready,
    output logic                                cpu_hit,
    output logic [INDEX_W-1:0]                  set_index,
    output logic [TAG_W-1:0]                    set_tag,
    output logic                                set_en,
    output logic                                set_en_check,
    output logic                                set_en_alloc,
    output logic                                set_en_evict,
    output logic                                set_en_change,
    input  logic                                set_hit,
    input  logic                                set_dirty,
    input  logic                                set_valid,
    input  logic [TAG_W-1:0]                    set_victim_tag,
    output logic                                mem_req,
    output logic                                mem_we,
    output logic [TAG_W+INDEX_W+OFFSET_W-1:0]   mem_addr,
`ifdef CACHE_CTRL_STATS_EN
    output logic [15:0]                         stat_hits,
    output logic [15:0]                         stat_misses,
`endif
    input  logic                                mem_ack
);

    localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;
    localparam int LINE_W = TAG_W + INDEX_W;

    typedef enum logic [2:0] {
        S_IDLE, S_COMPARE, S_UPDATE, S_WRITEBACK,
        S_EVICT, S_FETCH, S_FILL, S_RESPOND
    } state_t;

    state_t              r_state;
    logic [LINE_W-1:0]   r_line;        // {tag, index} of the request
    logic                r_we;
    logic                r_refill;      // set after a fill: next compare is the final one
    logic                r_first_hit;
    logic [TAG_W-1:0]    r_victim_tag;

    state_t              w_next_state;
    logic [LINE_W-1:0]   w_line;
    logic                w_we;
    logic                w_refill;
    logic                w_first_hit;
    logic [TAG_W-1:0]    w_victim_tag;

    // Offset bits never matter: memory traffic is whole lines.
    logic w_unused_offset;
    assign w_unused_offset = ^cpu_addr[OFFSET_W-1:0];

    assign set_tag   = r_line[LINE_W-1:INDEX_W];
    assign set_index = r_line[INDEX_W-1:0];

    // Next-state and next-latch values. The same values feed both the state
    // register and the output register, so outputs change on the very edge
    // the state does and stay purely Moore.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        w_next_state = r_state;
        w_line       = r_line;
        w_we         = r_we;
        w_refill     = r_refill;
        w_first_hit  = r_first_hit;
        w_victim_tag = r_victim_tag;
        case (r_state)
            S_IDLE: begin
                if (cpu_req) begin
                    w_line       = cpu_addr[ADDR_W-1:OFFSET_W];
                    w_we         = cpu_we;
                    w_refill     = 1'b0;
                    w_next_state = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (!r_refill) w_first_hit = set_hit;
                if (set_hit) begin
                    w_next_state = r_we ? S_UPDATE : S_RESPOND;
                end else if (r_refill) begin
                    // Line was just filled and still misses: give up, no retry.
                    w_next_state = S_RESPOND;
                end else if (set_valid && set_dirty) begin
                    w_victim_tag = set_victim_tag;
                    w_next_state = S_WRITEBACK;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_UPDATE:    w_next_state = S_RESPOND;
            S_WRITEBACK: if (mem_ack) w_next_state = S_EVICT;
            S_EVICT:     w_next_state = S_FETCH;
            S_FETCH:     if (mem_ack) w_next_state = S_FILL;
            S_FILL: begin
                w_refill     = 1'b1;
                w_next_state = S_COMPARE;
            end
            S_RESPOND:   w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_line        <= '0;
            r_we          <= 1'b0;
            r_refill      <= 1'b0;
            r_first_hit   <= 1'b0;
            r_victim_tag  <= '0;
            cpu_ready     <= 1'b0;
            cpu_hit       <= 1'b0;
            set_en        <= 1'b0;
            set_en_check  <= 1'b0;
            set_en_alloc  <= 1'b0;
            set_en_evict  <= 1'b0;
            set_en_change <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples
            // pre-edge values regardless of statement order.
            r_state       <= w_next_state;
            r_line        <= w_line;
            r_we          <= w_we;
            r_refill      <= w_refill;
            r_first_hit   <= w_first_hit;
            r_victim_tag  <= w_victim_tag;
            cpu_ready     <= (w_next_state == S_RESPOND);
            cpu_hit       <= (w_next_state == S_RESPOND) && w_first_hit;
            set_en        <= (w_next_state == S_UPDATE) || (w_next_state == S_FILL);
            set_en_check  <= (w_next_state == S_COMPARE);
            set_en_alloc  <= (w_next_state == S_FILL);
            set_en_evict  <= (w_next_state == S_EVICT);
            set_en_change <= (w_next_state == S_UPDATE);
            mem_req       <= (w_next_state == S_WRITEBACK) || (w_next_state == S_FETCH);
            mem_we        <= (w_next_state == S_WRITEBACK);
            case (w_next_state)
                S_WRITEBACK: mem_addr <= {w_victim_tag, w_line[INDEX_W-1:0], {OFFSET_W{1'b0}}};
                S_FETCH:     mem_addr <= {w_line, {OFFSET_W{1'b0}}};
                default:     mem_addr <= '0;
            endcase
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] r_stat_hits;
    logic [15:0] r_stat_misses;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
        end else if (r_state == S_RESPOND) begin
            if (r_first_hit) begin
                if (r_stat_hits != 16'hFFFF) r_stat_hits <= r_stat_hits + 16'd1;
            end else begin
                if (r_stat_misses != 16'hFFFF) r_stat_misses <= r_stat_misses + 16'd1;
            end
        end
    end

    assign stat_hits   = r_stat_hits;
    assign stat_misses = r_stat_misses;
`endif

endmodule

// File: tb/tb_cache_set_ctrl.sv
// Bench for cache_set_ctrl: a table of complete CPU transactions with the
// set/memory responder behaviour and the expected observable results, plus
// hand-written reset and late-ack sequences.
module tb_cache_set_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr;
    logic        cpu_ready, cpu_hit;
    logic [8:0]  set_index;
    logic [18:0] set_tag;
    logic        set_en, set_en_check, set_en_alloc, set_en_evict, set_en_change;
    logic        set_hit, set_dirty, set_valid;
    logic [18:0] set_victim_tag;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr;
`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] stat_hits, stat_misses;
`endif

    always #5 clk = ~clk;

    cache_set_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_ready(cpu_ready), .cpu_hit(cpu_hit),
        .set_index(set_index), .set_tag(set_tag),
        .set_en(set_en), .set_en_check(set_en_check), .set_en_alloc(set_en_alloc),
        .set_en_evict(set_en_evict), .set_en_change(set_en_change),
        .set_hit(set_hit), .set_dirty(set_dirty), .set_valid(set_valid),
        .set_victim_tag(set_victim_tag),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
`ifdef CACHE_CTRL_STATS_EN
        .stat_hits(stat_hits), .stat_misses(stat_misses),
`endif
        .mem_ack(mem_ack)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic        hit1, hit2, valid, dirty;
        logic [18:0] victim;
        int          wb_dly, fe_dly;
        int          e_lat;
        logic        e_hit;
        int          e_alloc, e_evict, e_change, e_wb, e_fe, e_mem;
        logic [31:0] e_wb_addr, e_fe_addr;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [31:0] strobes();
        return {23'd0, cpu_ready, cpu_hit, set_en, set_en_check, set_en_alloc,
                set_en_evict, set_en_change, mem_req, mem_we};
    endfunction

    // Drives one request and acts as set + memory model until cpu_ready.
    task automatic run_txn(input vec_t v, input int idx);
        int cyc = 0, ncmp = 0, nalloc = 0, nevict = 0, nchange = 0, nen = 0;
        int nwb = 0, nfe = 0, nmem = 0, wcnt = 0, lat = 0, first_chk = 0, bad_tag = 0;
        logic got = 1'b0, hit = 1'b0, prev_req = 1'b0;
        logic [31:0] wb_addr = '0, fe_addr = '0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr;
        set_valid = v.valid; set_dirty = v.dirty; set_victim_tag = v.victim;
        set_hit = 1'b0; mem_ack = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            cpu_req = 1'b0;
            if (set_tag !== v.addr[31:13] || set_index !== v.addr[12:4]) bad_tag++;
            if (set_en_check) begin
                if (first_chk == 0) first_chk = cyc;
                set_hit = (ncmp == 0) ? v.hit1 : v.hit2;
                ncmp++;
            end else begin
                set_hit = 1'b0;
            end
            if (set_en_alloc)  nalloc++;
            if (set_en_evict)  nevict++;
            if (set_en_change) nchange++;
            if (set_en)        nen++;
            if (mem_req) begin
                if (!prev_req) begin
                    wcnt = 0;
                    if (mem_we) nwb++; else nfe++;
                end
                if (mem_we) wb_addr = mem_addr; else fe_addr = mem_addr;
                mem_ack = (wcnt >= (mem_we ? v.wb_dly : v.fe_dly));
                wcnt++;
                nmem++;
            end else begin
                mem_ack = 1'b0;
            end
            prev_req = mem_req;
            if (cpu_ready) begin
                got = 1'b1; lat = cyc; hit = cpu_hit;
            end
        end
        check($sformatf("v%0d ready_seen", idx), 32'(got), 32'd1);
        check($sformatf("v%0d latency", idx), lat, v.e_lat);
        check($sformatf("v%0d cpu_hit", idx), 32'(hit), 32'(v.e_hit));
        check($sformatf("v%0d first_check_cycle", idx), first_chk, 1);
        check($sformatf("v%0d alloc_pulses", idx), nalloc, v.e_alloc);
        check($sformatf("v%0d evict_pulses", idx), nevict, v.e_evict);
        check($sformatf("v%0d change_pulses", idx), nchange, v.e_change);
        check($sformatf("v%0d en_pulses", idx), nen, v.e_alloc + v.e_change);
        check($sformatf("v%0d wb_phases", idx), nwb, v.e_wb);
        check($sformatf("v%0d fetch_phases", idx), nfe, v.e_fe);
        check($sformatf("v%0d mem_cycles", idx), nmem, v.e_mem);
        check($sformatf("v%0d wb_addr", idx), wb_addr, v.e_wb_addr);
        check($sformatf("v%0d fetch_addr", idx), fe_addr, v.e_fe_addr);
        check($sformatf("v%0d tag_index_stable", idx), bad_tag, 0);
        @(negedge clk);
        check($sformatf("v%0d idle_after", idx), strobes(), 32'd0);
    endtask

    initial begin
        //           we  addr          h1 h2 vl dt victim     wbd fed lat hit al ev ch wb fe mem wb_addr       fe_addr
        vecs[0] = '{1'b0, 32'h0000_1230, 1, 0, 0, 0, 19'h0,     0, 0,  2, 1, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0};
        vecs[1] = '{1'b1, 32'h0000_1230, 1, 0, 0, 0, 19'h0,     0, 0,  3, 1, 0, 0, 1, 0, 0, 0, 32'h0,         32'h0};
        vecs[2] = '{1'b0, 32'h0000_1230, 0, 1, 0, 0, 19'h0,     0, 3,  8, 0, 1, 0, 0, 0, 1, 4, 32'h0,         32'h0000_1230};
        vecs[3] = '{1'b0, 32'h0000_1230, 0, 1, 1, 1, 19'h7ABCD, 0, 0,  7, 0, 1, 1, 0, 1, 1, 2, 32'hF579_B230, 32'h0000_1230};
        vecs[4] = '{1'b0, 32'h0000_1230, 0, 0, 0, 0, 19'h0,     0, 1,  6, 0, 1, 0, 0, 0, 1, 2, 32'h0,         32'h0000_1230};
        vecs[5] = '{1'b0, 32'hDEAD_BEEF, 0, 1, 1, 0, 19'h7ABCD, 0, 0,  5, 0, 1, 0, 0, 0, 1, 1, 32'h0,         32'hDEAD_BEE0};
        vecs[6] = '{1'b0, 32'h8000_000F, 0, 1, 0, 1, 19'h7ABCD, 0, 0,  5, 0, 1, 0, 0, 0, 1, 1, 32'h0,         32'h8000_0000};
        vecs[7] = '{1'b1, 32'h1234_5678, 0, 1, 1, 1, 19'h00001, 2, 1, 11, 0, 1, 1, 1, 1, 1, 5, 32'h0000_3670, 32'h1234_5670};

        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
        set_hit = 1'b0; set_dirty = 1'b0; set_valid = 1'b0; set_victim_tag = '0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("reset strobes", strobes(), 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset tag_index", {4'd0, set_tag, set_index}, 32'd0);
`ifdef CACHE_CTRL_STATS_EN
        check("reset stats", {stat_hits, stat_misses}, 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], i);
`ifdef CACHE_CTRL_STATS_EN
            if (i == 2) check("stats after 2 hits 1 miss", {stat_hits, stat_misses}, {16'd2, 16'd1});
`endif
        end
`ifdef CACHE_CTRL_STATS_EN
        check("stats after table", {stat_hits, stat_misses}, {16'd2, 16'd6});
`endif

        // Reset while waiting in write-back, then a late ack must be ignored.
        begin
            int  t = 0;
            logic [31:0] acc = '0;
            @(negedge clk);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1230;
            set_valid = 1'b1; set_dirty = 1'b1; set_victim_tag = 19'h7ABCD;
            @(negedge clk);
            cpu_req = 1'b0;
            while (!(mem_req && mem_we) && t < 20) begin
                @(negedge clk);
                t++;
            end
            check("rst_seq reached writeback", 32'(mem_req && mem_we), 32'd1);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("rst_seq strobes cleared", strobes(), 32'd0);
            check("rst_seq mem_addr cleared", mem_addr, 32'd0);
            check("rst_seq tag_index cleared", {4'd0, set_tag, set_index}, 32'd0);
`ifdef CACHE_CTRL_STATS_EN
            check("rst_seq stats cleared", {stat_hits, stat_misses}, 32'd0);
`endif
            mem_ack = 1'b1;
            repeat (3) begin
                @(negedge clk);
                acc |= strobes();
            end
            mem_ack = 1'b0;
            check("rst_seq late ack ignored", acc, 32'd0);
        end

        run_txn(vecs[0], 8);
        run_txn(vecs[3], 9);
`ifdef CACHE_CTRL_STATS_EN
        check("stats after reset seq", {stat_hits, stat_misses}, {16'd1, 16'd1});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
